// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the requester-side and memory-side signals of mem_arbiter.
//
// Requester side (flattened per-requester vectors, requester i owns slice i):
//   req, lock, we       : per-requester request, burst lock, write enable
//   addr, wdata         : flattened payloads, slice [i*W +: W]
//   gnt                 : one-hot grant, transfer when req[i] & gnt[i]
//   rvalid, rdata       : one-cycle read response pulse and shared read data
// Memory side:
//   mem_en, mem_we, mem_addr, mem_wdata : access strobe and payload
//   mem_rdata           : read data, valid one cycle after a read strobe
//
// Modports: slave = the arbiter, master = requesters plus memory (e.g. a testbench).
interface mem_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 8
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        lock;
    logic [NUM_REQ-1:0]        we;
    logic [NUM_REQ*ADDR_W-1:0] addr;
    logic [NUM_REQ*DATA_W-1:0] wdata;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        rvalid;
    logic [DATA_W-1:0]         rdata;
    logic                      mem_en;
    logic                      mem_we;
    logic [ADDR_W-1:0]         mem_addr;
    logic [DATA_W-1:0]         mem_wdata;
    logic [DATA_W-1:0]         mem_rdata;

    modport slave (
        input  req, lock, we, addr, wdata, mem_rdata,
        output gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req, lock, we, addr, wdata, mem_rdata,
        input  gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one single-port memory among NUM_REQ requesters.
//
// At most one transfer per cycle, granted combinationally in the same cycle the request is
// presented. Locked bursts keep the grant on one owner for up to MAX_BURST grants, after which
// rotation is forced. Read data returns one cycle after the read grant, tagged by rvalid to
// the issuing requester.
//
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous active-low reset
//   bus : mem_arbiter_if.slave (requester request/grant/response + memory strobe/payload)
//
// Optional feature, macro MEM_ARB_PRIO0_EN:
//   requester 0 gets strict priority in arbitration (rr_ptr not updated on its wins) and
//   ends a burst locked by another requester, so requester 0 wins on the following cycle.
module mem_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);

    localparam int unsigned ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [0:0] {StArb, StLocked} state_e;

    state_e            state_q;
    logic [ID_W-1:0]   rr_ptr_q;
    logic [ID_W-1:0]   owner_q;
    logic [CNT_W-1:0]  burst_cnt_q;
    logic              pend_valid_q;
    logic [ID_W-1:0]   pend_id_q;
    logic [DATA_W-1:0] rdata_q;

    // Round-robin search result for the ARB state.
    logic              arb_found;
    logic [ID_W-1:0]   arb_win;
    logic [ID_W-1:0]   scan_id;
    logic              prio_hit;
    logic              preempt;

    // Grant decision for the current cycle.
    logic              grant_any;
    logic              grant_ok;
    logic [ID_W-1:0]   win;
    logic              win_is_read;

    // Search starts just after rr_ptr and wraps, so the last winner has lowest priority.
    always_comb begin
        arb_found = 1'b0;
        arb_win   = rr_ptr_q;
        scan_id   = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            scan_id = ID_W'((32'(rr_ptr_q) + i) % NUM_REQ);
            if (!arb_found && bus.req[scan_id]) begin
                arb_found = 1'b1;
                arb_win   = scan_id;
            end
        end
`ifdef MEM_ARB_PRIO0_EN
        prio_hit = bus.req[0];
        if (prio_hit) begin
            arb_found = 1'b1;
            arb_win   = '0;
        end
        // A pending requester-0 request ends someone else's burst after this cycle.
        preempt = bus.req[0] && (owner_q != '0);
`else
        prio_hit = 1'b0;
        preempt  = 1'b0;
`endif
    end

    always_comb begin
        grant_any = 1'b0;
        win       = arb_win;
        unique case (state_q)
            StArb: begin
                grant_any = arb_found;
                win       = arb_win;
            end
            StLocked: begin
                grant_any = bus.req[owner_q];
                win       = owner_q;
            end
            default: begin
                grant_any = 1'b0;
                win       = arb_win;
            end
        endcase
        // Outputs are forced quiet while reset is asserted, even with requests pending.
        grant_ok    = grant_any && rst;
        win_is_read = grant_ok && !bus.we[win];
    end

    // Grant and memory-side muxes.
    always_comb begin
        bus.gnt = '0;
        if (grant_ok) begin
            bus.gnt[win] = 1'b1;
        end
        bus.mem_en    = |(bus.req & bus.gnt);
        bus.mem_we    = grant_ok ? bus.we[win] : 1'b0;
        bus.mem_addr  = grant_ok ? bus.addr[32'(win) * ADDR_W +: ADDR_W] : '0;
        bus.mem_wdata = grant_ok ? bus.wdata[32'(win) * DATA_W +: DATA_W] : '0;
    end

    // Read response: memory data arrives the cycle after the strobe and is passed straight
    // through; rdata_q keeps the last returned value for the cycles in between.
    always_comb begin
        bus.rvalid = '0;
        if (pend_valid_q) begin
            bus.rvalid[pend_id_q] = 1'b1;
        end
        bus.rdata = pend_valid_q ? bus.mem_rdata : rdata_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StArb;
            rr_ptr_q     <= ID_W'(NUM_REQ - 1);
            owner_q      <= '0;
            burst_cnt_q  <= '0;
            pend_valid_q <= 1'b0;
            pend_id_q    <= '0;
            rdata_q      <= '0;
        end else begin
            pend_valid_q <= win_is_read;
            if (win_is_read) begin
                pend_id_q <= win;
            end
            if (pend_valid_q) begin
                rdata_q <= bus.mem_rdata;
            end

            unique case (state_q)
                StArb: begin
                    if (arb_found) begin
                        if (!prio_hit) begin
                            rr_ptr_q <= arb_win;
                        end
                        if (bus.lock[arb_win] && (MAX_BURST > 1)) begin
                            state_q     <= StLocked;
                            owner_q     <= arb_win;
                            burst_cnt_q <= CNT_W'(1);
                        end
                    end
                end
                StLocked: begin
                    if (bus.req[owner_q] && bus.lock[owner_q] &&
                        (burst_cnt_q == CNT_W'(MAX_BURST - 1))) begin
                        // Burst cap reached with this grant: hand priority to owner+1.
                        state_q     <= StArb;
                        rr_ptr_q    <= owner_q;
                        burst_cnt_q <= '0;
                    end else if (!bus.req[owner_q] || !bus.lock[owner_q] || preempt) begin
                        state_q     <= StArb;
                        burst_cnt_q <= '0;
                    end else begin
                        burst_cnt_q <= burst_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q     <= StArb;
                    burst_cnt_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter (NUM_REQ=4, ADDR_W=8, DATA_W=8,
// MAX_BURST=4). The driver pushes the expected grant of every driven cycle and the expected
// read response of every read it issues; a negedge monitor pops and compares.
// Memory contents start as mem[a] = a ^ 8'h3C.
module tb_mem_arbiter;

    localparam int unsigned NUM_REQ   = 4;
    localparam int unsigned ADDR_W    = 8;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned MAX_BURST = 4;

    localparam logic [31:0] A_DEF = 32'h23222120;   // req3..req0 addresses 23,22,21,20
    localparam logic [31:0] A_T3  = 32'h23101020;   // req2 and req1 at address 10
    localparam logic [31:0] D_T3  = 32'h00A50000;   // req2 writes A5

    typedef struct {
        logic [3:0] vec;
        logic [7:0] data;
        int         stamp;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    logic [3:0] gnt_q[$];
    rsp_t       rsp_q[$];
    logic [7:0] mem[256];

    logic [3:0] mon_eg;
    rsp_t       mon_r;

    mem_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MAX_BURST(MAX_BURST)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Single-port memory with one-cycle read latency.
    initial begin
        for (int a = 0; a < 256; a++) mem[a] = 8'(a) ^ 8'h3C;
    end
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata <= mem[bus.mem_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive(input logic [3:0] r, input logic [3:0] l, input logic [3:0] w,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] eg, input logic [7:0] ed, input bit track);
        rsp_t e;
        @(posedge clk);
        #1;
        bus.req   = r;
        bus.lock  = l;
        bus.we    = w;
        bus.addr  = a;
        bus.wdata = d;
        gnt_q.push_back(eg);
        if (track && ((eg & ~w) != 4'b0)) begin
            e.vec   = eg;
            e.data  = ed;
            e.stamp = cyc;
            rsp_q.push_back(e);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_gnt"},    32'(bus.gnt), 32'h0);
        check({tag, "_rvalid"}, 32'(bus.rvalid), 32'h0);
        check({tag, "_rdata"},  32'(bus.rdata), 32'h0);
        check({tag, "_mem_en"}, 32'(bus.mem_en), 32'h0);
        check({tag, "_mem_we"}, 32'(bus.mem_we), 32'h0);
        check({tag, "_addr"},   32'(bus.mem_addr), 32'h0);
        check({tag, "_wdata"},  32'(bus.mem_wdata), 32'h0);
    endtask

    // Monitor: compares whatever the DUT presents against the queued expectations.
    always @(negedge clk) begin
        if (rst) begin
            if (gnt_q.size() != 0) begin
                mon_eg = gnt_q.pop_front();
                check("gnt", 32'(bus.gnt), 32'(mon_eg));
                check("mem_en", 32'(bus.mem_en), 32'(|mon_eg));
                check("gnt_onehot0", 32'($onehot0(bus.gnt)), 32'h1);
            end
            if (rsp_q.size() != 0 && rsp_q[0].stamp + 1 < cyc) begin
                mon_r = rsp_q.pop_front();
                n_tests++;
                n_fail++;
                $display("FAIL missing_rvalid: got none, expected rvalid %b issued cycle %0d",
                         mon_r.vec, mon_r.stamp);
            end
            if (bus.rvalid != 4'b0) begin
                if (rsp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_rvalid: got %b, expected none (cycle %0d)",
                             bus.rvalid, cyc);
                end else begin
                    mon_r = rsp_q.pop_front();
                    check("rvalid", 32'(bus.rvalid), 32'(mon_r.vec));
                    check("rdata", 32'(bus.rdata), 32'(mon_r.data));
                    check("rsp_timing", cyc, mon_r.stamp + 1);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.req   = '0;
        bus.lock  = '0;
        bus.we    = '0;
        bus.addr  = A_DEF;
        bus.wdata = '0;
        bus.mem_rdata = '0;
        #1;
        check_quiet("por");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Reset mid-burst with a read in flight: requester 1 locked.
        drive(4'b0010, 4'b0010, 4'b0000, A_DEF, 32'h0, 4'b0010, 8'h1D, 1'b1);
        drive(4'b0010, 4'b0010, 4'b0000, A_DEF, 32'h0, 4'b0010, 8'h00, 1'b0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        bus.req  = 4'b1111;
        bus.lock = 4'b1111;
        #1;
        check_quiet("rst");
        @(posedge clk);
        #1;
        check("rst_gnt2", 32'(bus.gnt), 32'h0);
        check("rst_rvalid2", 32'(bus.rvalid), 32'h0);
        @(negedge clk);
        bus.req  = '0;
        bus.lock = '0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_rvalid", 32'(bus.rvalid), 32'h0);

        // First grant after reset goes to requester 0.
        drive(4'b1111, 4'b0000, 4'b0000, A_DEF, 32'h0, 4'b0001, 8'h1C, 1'b1);
`ifndef MEM_ARB_PRIO0_EN
        // Rotation with all reads.
        drive(4'b1111, 4'b0000, 4'b0000, A_DEF, 32'h0, 4'b0010, 8'h1D, 1'b1);
        drive(4'b1111, 4'b0000, 4'b0000, A_DEF, 32'h0, 4'b0100, 8'h1E, 1'b1);
        drive(4'b1111, 4'b0000, 4'b0000, A_DEF, 32'h0, 4'b1000, 8'h1F, 1'b1);
        drive(4'b1111, 4'b0000, 4'b0000, A_DEF, 32'h0, 4'b0001, 8'h1C, 1'b1);

        // Write then read: requester 2 writes A5 @10, requester 1 reads @10.
        drive(4'b0100, 4'b0000, 4'b0100, A_T3, D_T3, 4'b0100, 8'h00, 1'b1);
        drive(4'b0010, 4'b0000, 4'b0000, A_T3, D_T3, 4'b0010, 8'hA5, 1'b1);

        // Lock cap: park rr_ptr at 0, then requester 1 bursts 4 times before requester 3.
        drive(4'b0001, 4'b0000, 4'b0000, A_T3, D_T3, 4'b0001, 8'h1C, 1'b1);
        for (int k = 0; k < 4; k++) begin
            drive(4'b1010, 4'b0010, 4'b0000, A_T3, D_T3, 4'b0010, 8'hA5, 1'b1);
        end
        drive(4'b1010, 4'b0010, 4'b0000, A_T3, D_T3, 4'b1000, 8'h1F, 1'b1);
        drive(4'b0000, 4'b0000, 4'b0000, A_T3, D_T3, 4'b0000, 8'h00, 1'b1);

        // Lock release on the second request, then rotation resumes at requester 1.
        drive(4'b1111, 4'b0001, 4'b0000, A_T3, D_T3, 4'b0001, 8'h1C, 1'b1);
        drive(4'b1111, 4'b0000, 4'b0000, A_T3, D_T3, 4'b0001, 8'h1C, 1'b1);
        drive(4'b1111, 4'b0000, 4'b0000, A_T3, D_T3, 4'b0010, 8'hA5, 1'b1);
        drive(4'b1111, 4'b0000, 4'b0000, A_T3, D_T3, 4'b0100, 8'hA5, 1'b1);

        // Owner drops req for a cycle: no grant that cycle even with others waiting.
        drive(4'b1000, 4'b1000, 4'b0000, A_T3, D_T3, 4'b1000, 8'h1F, 1'b1);
        drive(4'b0010, 4'b0000, 4'b0000, A_T3, D_T3, 4'b0000, 8'h00, 1'b1);
        drive(4'b0010, 4'b0000, 4'b0000, A_T3, D_T3, 4'b0010, 8'hA5, 1'b1);
`else
        // Requester 2 locks; requester 0 pre-empts the next cycle and keeps winning.
        drive(4'b0100, 4'b0100, 4'b0000, A_DEF, 32'h0, 4'b0100, 8'h1E, 1'b1);
        drive(4'b0101, 4'b0100, 4'b0000, A_DEF, 32'h0, 4'b0100, 8'h1E, 1'b1);
        for (int k = 0; k < 3; k++) begin
            drive(4'b0101, 4'b0100, 4'b0000, A_DEF, 32'h0, 4'b0001, 8'h1C, 1'b1);
        end
        drive(4'b0100, 4'b0100, 4'b0000, A_DEF, 32'h0, 4'b0100, 8'h1E, 1'b1);
`endif
        drive(4'b0000, 4'b0000, 4'b0000, A_T3, D_T3, 4'b0000, 8'h00, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("rsp_q_drained", 32'(rsp_q.size()), 32'h0);
        check("gnt_q_drained", 32'(gnt_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
